// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI blocks: frame opcodes, the 3-bit state
// encoding used by every SPI state machine, and default word widths.
// No ports (package).
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int WORD_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RX    = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_t;

endpackage

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
// Sends one command word per frame, MSB first, on MOSI with SS_n low. The
// command bit is presented twice (accept edge and select edge). Read-data
// frames keep SS_n low, wait RD_WAIT-1 cycles, then capture DATA_W bits from
// MISO MSB first. SS_n is high for at least two cycles between frames.
//
// Ports:
//   clk       in   single rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   frame request, sampled only when idle
//   cmd_word  in   frame word, top two bits are the opcode
//   busy      out  high from the accept edge until back in idle
//   done      out  one-cycle pulse at frame end
//   rd_data   out  last byte captured by a read-data frame
//   rd_valid  out  one-cycle pulse with done on read-data frames
//   MOSI      out  registered serial data to slave
//   SS_n      out  registered active-low slave select
//   MISO      in   serial data from slave
// ---------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cmd_word,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              MOSI,
    output logic              SS_n,
    input  logic              MISO
);

    localparam logic [3:0] SHIFT_LAST = 4'(WORD_W);
    localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 2);
    localparam logic [3:0] RX_LAST    = 4'(DATA_W - 1);

    spi_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [1:0]        op_q, op_d;
    logic              mosi_q, mosi_d;
    logic              ss_n_q, ss_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Every output is a flop, so the whole block is one register bank fed
    // by the next-state logic below. Reset lands the block in idle with the
    // slave deselected and the read-back byte cleared, whatever state it was
    // in, so an interrupted frame is simply abandoned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sreg_q     <= '0;
            op_q       <= '0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            op_q       <= op_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Next-state and next-output logic. Registers hold by default and the
    // two pulse outputs default low, so done/rd_valid can only be high for
    // the single cycle after the edge that ends a frame. The one shift
    // register carries the outgoing word during SHIFT and is reused to
    // collect MISO bits during RX; the opcode is kept separately because
    // the word has been shifted away by the time the frame end is decided.
    // When RD_WAIT is 1 the wait phase has zero length and SHIFT goes
    // straight to RX.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        op_d       = op_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sreg_d  = cmd_word;
                    op_d    = cmd_word[WORD_W-1 -: 2];
                    mosi_d  = cmd_word[WORD_W-1];
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SEL;
                end
            end

            ST_SEL: begin
                mosi_d  = sreg_q[WORD_W-1];
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    mosi_d = 1'b0;
                    cnt_d  = '0;
                    if (op_q == OP_RD_DATA) begin
                        state_d = (RD_WAIT == 1) ? ST_RX : ST_WAIT;
                    end else begin
                        ss_n_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_GAP;
                    end
                end else begin
                    mosi_d = sreg_q[WORD_W-1];
                    sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
                    cnt_d  = cnt_q + 4'd1;
                end
            end

            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RX;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_RX: begin
                sreg_d = {sreg_q[WORD_W-2:0], MISO};
                if (cnt_q == RX_LAST) begin
                    rd_data_d  = {sreg_q[DATA_W-2:0], MISO};
                    rd_valid_d = 1'b1;
                    done_d     = 1'b1;
                    ss_n_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_GAP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign MOSI     = mosi_q;
    assign SS_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master
// Directed self-checking bench for spi_master. A small frame model derives
// the expected MOSI/SS_n/busy/done/rd_valid/rd_data after every edge from
// the command word and the byte the slave model returns.
// ---------------------------------------------------------------------------
module tb_spi_master;
    import spi_pkg::*;

    localparam int WORD_W  = 10;
    localparam int DATA_W  = 8;
    localparam int RD_WAIT = 3;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              MISO     = 1'b0;
    logic [WORD_W-1:0] cmd_word = '0;
    logic              busy;
    logic              done;
    logic              rd_valid;
    logic              MOSI;
    logic              SS_n;
    logic [DATA_W-1:0] rd_data;

    int                check_count   = 0;
    int                fail_count    = 0;
    logic [DATA_W-1:0] model_rd_data = '0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    spi_master #(
        .WORD_W  (WORD_W),
        .DATA_W  (DATA_W),
        .RD_WAIT (RD_WAIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmd_word (cmd_word),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .MOSI     (MOSI),
        .SS_n     (SS_n),
        .MISO     (MISO)
    );

    // Guards against a hung run; the stimulus itself only uses bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [WORD_W-1:0] cmd);
        start    = s;
        cmd_word = cmd;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " ss_n"},     32'(SS_n),     32'd1);
        checkOutput({tag, " mosi"},     32'(MOSI),     32'd0);
        checkOutput({tag, " busy"},     32'(busy),     32'd0);
        checkOutput({tag, " done"},     32'(done),     32'd0);
        checkOutput({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, " rd_data"},  32'(rd_data),  32'(model_rd_data));
    endtask

    // Runs one frame from idle and checks every output after each edge,
    // including two edges after the frame to confirm no second frame starts.
    // With disturb set, start is pulsed into edges 5 and 12 and cmd_word is
    // scrambled after the accept edge; none of that may alter the frame.
    task automatic runFrame(input logic [WORD_W-1:0] cmd, input logic [DATA_W-1:0] slave_byte,
                            input bit disturb);
        bit   is_rd;
        int   end_edge;
        logic exp_mosi;
        is_rd    = (cmd[WORD_W-1 -: 2] == OP_RD_DATA);
        end_edge = is_rd ? (12 + RD_WAIT + DATA_W - 1) : 12;
        applyStimulus(1'b1, cmd);
        for (int k = 0; k <= end_edge + 2; k++) begin
            tick();
            if (is_rd && k == end_edge) model_rd_data = slave_byte;
            if (k <= 1)       exp_mosi = cmd[WORD_W-1];
            else if (k <= 11) exp_mosi = cmd[11-k];
            else              exp_mosi = 1'b0;
            checkOutput($sformatf("%h mosi e%0d", cmd, k), 32'(MOSI), 32'(exp_mosi));
            checkOutput($sformatf("%h ss_n e%0d", cmd, k), 32'(SS_n), 32'(k >= end_edge));
            checkOutput($sformatf("%h busy e%0d", cmd, k), 32'(busy), 32'(k <= end_edge));
            checkOutput($sformatf("%h done e%0d", cmd, k), 32'(done), 32'(k == end_edge));
            checkOutput($sformatf("%h rd_valid e%0d", cmd, k), 32'(rd_valid),
                        32'(is_rd && k == end_edge));
            checkOutput($sformatf("%h rd_data e%0d", cmd, k), 32'(rd_data), 32'(model_rd_data));
            applyStimulus(disturb && (k == 4 || k == 11), disturb ? ~cmd : cmd);
            if (is_rd && k >= 11 + RD_WAIT && k <= 10 + RD_WAIT + DATA_W)
                MISO = slave_byte[10 + RD_WAIT + DATA_W - k];
            else
                MISO = 1'b0;
        end
    endtask

    initial begin
        $display("[TB] spi_master bench starting");

        // Reset state.
        rst_n = 1'b0;
        tick();
        tick();
        checkIdle("reset");
        rst_n = 1'b1;
        tick();
        checkIdle("post-reset");

        // Read-addr frame leaves rd_data untouched, then a read-data frame.
        runFrame(10'h2FF, 8'h00, 1'b0);
        runFrame(10'h300, 8'hC3, 1'b0);

        // Write-addr and write-data frames.
        runFrame(10'h0A5, 8'h00, 1'b0);
        runFrame(10'h13C, 8'h00, 1'b0);

        // start pulsed mid-frame and at the done edge, cmd_word scrambled.
        runFrame(10'h0A5, 8'h00, 1'b1);

        // start held high: frames at edges 0, 14, 28 with a 2-cycle SS_n gap.
        applyStimulus(1'b1, 10'h1C3);
        for (int k = 0; k < 30; k++) begin
            tick();
            checkOutput($sformatf("cont ss_n e%0d", k), 32'(SS_n), 32'((k % 14) >= 12));
            checkOutput($sformatf("cont busy e%0d", k), 32'(busy), 32'((k % 14) != 13));
            checkOutput($sformatf("cont done e%0d", k), 32'(done), 32'((k % 14) == 12));
        end
        applyStimulus(1'b0, 10'h1C3);
        for (int k = 30; k <= 41; k++) tick();
        checkIdle("cont end");

        // Reset at edge 7 of a read-data frame, then a fresh frame.
        applyStimulus(1'b1, 10'h300);
        tick();
        applyStimulus(1'b0, 10'h300);
        for (int k = 1; k <= 6; k++) tick();
        checkOutput("abort busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        model_rd_data = '0;
        checkIdle("abort e7");
        rst_n = 1'b1;
        tick();
        tick();
        checkIdle("abort no resume");
        runFrame(10'h3A5, 8'h5A, 1'b0);
        runFrame(10'h100, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter WORD_W, default 10, frame word width; bits [9:8] are the opcode, bits [7:0] the address or data.
REQ-002 Parameter DATA_W, default 8, width of the read-back byte on MISO.
REQ-003 Parameter RD_WAIT, default 3, cycles from edge 12 to the first MISO sample edge; legal range 1..7.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  request a frame; sampled only in IDLE.
REQ-007 cmd_word  in  WORD_W  frame word; opcode 00 = write-addr, 01 = write-data, 10 = read-addr, 11 = read-data.
REQ-008 busy  out  1  high from the accept edge until return to IDLE.
REQ-009 done  out  1  one-cycle pulse at frame end.
REQ-010 rd_data  out  DATA_W  byte captured from MISO, MSB first.
REQ-011 rd_valid  out  1  one-cycle pulse with done, read-data frames only.
REQ-012 MOSI  out  1  serial data to slave, registered.
REQ-013 SS_n  out  1  active-low slave select, registered.
REQ-014 MISO  in  1  serial data from slave.

Function
REQ-015 States: IDLE, SEL, SHIFT, WAIT, RX, GAP; cnt (4 bits) and an internal shift register.
REQ-016 In IDLE, start=1 at edge 0 latches cmd_word, sets SS_n<=0, MOSI<=cmd_word[9], busy<=1, and enters SEL.
REQ-017 SEL lasts one cycle and holds MOSI at cmd_word[9] at edge 1, so the command bit is presented twice.
REQ-018 SHIFT drives MOSI<=word[9-(k-2)] at edges k=2..11, MSB first; word[0] is driven at edge 11.
REQ-019 Non-read-data opcodes, edge 12: SS_n<=1, MOSI<=0, done<=1, enter GAP.
REQ-020 Opcode 11, edge 12: MOSI<=0, SS_n stays 0, enter WAIT; WAIT lasts RD_WAIT-1 cycles, then RX.
REQ-021 RX samples MISO at edges 12+RD_WAIT through 19+RD_WAIT, shifting left (first sample becomes rd_data[7]).
REQ-022 On the last RX sample edge: rd_data<=captured byte, rd_valid<=1, done<=1, SS_n<=1, enter GAP.
REQ-023 GAP lasts one cycle with SS_n=1, then IDLE with busy<=0; SS_n is therefore high for at least 2 cycles between frames.
REQ-024 start is ignored while busy=1; cmd_word changes during a frame have no effect.
REQ-025 start asserted in the same cycle as done is ignored; start is accepted only once busy=0.
REQ-026 rd_data holds its value until the next read-data frame completes; other frames never modify it.
REQ-027 done and rd_valid are never high for more than one consecutive cycle.

Reset
REQ-028 rst_n=0 at any edge, including mid-frame, forces SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, cnt=0, and state IDLE on that edge.
REQ-029 A frame aborted by reset is not resumed; the first start accepted after rst_n returns to 1 begins a fresh frame.

Structure
REQ-030 Shared package spi_pkg holds the opcode constants, the state encoding (3-bit; same values used across the SPI blocks), and the WORD_W/DATA_W defaults.
REQ-031 The block is a single module with no sub-module; the shift register and counter are inline.

Verification
REQ-032 Write frame: start with cmd_word=10'h0A5 -> MOSI after edges 0..11 = 0,0,0,0,1,0,1,0,0,1,0,1; SS_n low after edges 0-11; done=1 after edge 12; rd_valid stays 0.
REQ-033 Read-data frame: cmd_word=10'h300, RD_WAIT=3, slave model drives 8'hC3 MSB first, timed so bits are sampled at edges 15-22 -> rd_data=8'hC3 and rd_valid=done=1 after edge 22; SS_n=1 after edge 22.
REQ-034 start pulsed at edges 5 and 12 of a write frame -> both ignored, no second frame; busy falls after edge 13.
REQ-035 rst_n=0 at edge 7 of a read-data frame -> SS_n=1, MOSI=0, busy=0 after edge 7; the next start yields a correct frame.
REQ-036 start held high continuously -> frames begin at edges 0, 14, 28, ...; SS_n high for 2 cycles between frames.
REQ-037 Read-addr frame (10'h2FF) followed by read-data frame -> after the first frame, rd_data keeps its reset value 0; rd_valid pulses only once, in the second frame.
